// File: rtl/ifu_fetch_stage_if.sv
// ifu_fetch_stage_if: instruction-memory request/ready port between the fetch stage and memory
interface ifu_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  modport master (output imem_req, imem_addr, input imem_rdata, imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_rdata, imem_ready);
endinterface

// File: rtl/ifu_fetch_stage.sv
// ifu_fetch_stage: F-stage PC, instruction fetch with wait/stall tolerance, and the F/D pipeline register
module ifu_fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter logic [31:0] IM_LIMIT = 32'h0000_6FFC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      npc_sel,
  input  logic [31:0]               NPC,
  ifu_fetch_stage_if.master         imem,
  output logic [31:0]               PC_F,
  output logic [31:0]               Instr_D,
  output logic [31:0]               PC_D,
  output logic                      valid_D,
  output logic                      exc_adel_D,
  output logic                      fetch_busy
);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_instr, r_pc_d, r_pend_pc, r_buf;
  logic        r_valid, r_exc, r_pend_v;
  logic        w_bad, w_avail, w_fire, w_capture;
  logic [31:0] w_word;
  assign w_bad      = (r_pc[1:0] != 2'b00) || (r_pc < IM_BASE) || (r_pc > IM_LIMIT);
  assign w_avail    = (r_state == FETCH && (imem.imem_ready || w_bad)) || r_state == HOLD;
  assign w_word     = (r_state == HOLD) ? r_buf : (w_bad ? 32'd0 : imem.imem_rdata);
  assign w_fire     = w_avail && !stall;
  assign w_capture  = r_state == FETCH && imem.imem_ready && stall && !w_bad;
  assign imem.imem_req  = r_state == FETCH && !w_bad;
  assign imem.imem_addr = r_pc;
  assign fetch_busy = r_state == FETCH && !imem.imem_ready && !w_bad;
  assign PC_F       = r_pc;
  assign Instr_D    = r_instr;
  assign PC_D       = r_pc_d;
  assign valid_D    = r_valid;
  assign exc_adel_D = r_exc;
  always_comb begin
    w_next = w_capture ? HOLD : (r_state == HOLD && !stall) ? FETCH : r_state;
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= FETCH;
    else       r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc      <= PC_RESET;
      r_instr   <= '0;
      r_pc_d    <= '0;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
      r_buf     <= '0;
    end else begin
      if (!stall) begin
        r_instr <= w_fire ? w_word : 32'd0;
        r_pc_d  <= r_pc;
        r_valid <= w_fire;
        r_exc   <= w_fire && w_bad;
      end
      // a redirect seen while F has nothing to hand over is kept until the delay slot leaves F
      if (w_fire) begin
        r_pc     <= npc_sel ? NPC : (r_pend_v ? r_pend_pc : r_pc + 32'd4);
        r_pend_v <= 1'b0;
      end else if (!stall && npc_sel) begin
        r_pend_v  <= 1'b1;
        r_pend_pc <= NPC;
      end
      if (w_capture) r_buf <= imem.imem_rdata;
    end
  end
endmodule

// File: tb/tb_ifu_fetch_stage.sv
// tb_ifu_fetch_stage: directed scoreboard bench for the fetch stage and F/D register
module tb_ifu_fetch_stage;
  logic        clk = 1'b0;
  logic        reset, stall, npc_sel;
  logic [31:0] NPC, PC_F, Instr_D, PC_D;
  logic        valid_D, exc_adel_D, fetch_busy;
  int          checks = 0, passed = 0;
  logic [31:0] cur_pc;
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        v;
    logic        e;
    logic [31:0] pcf;
  } exp_t;
  exp_t q[$];
  ifu_fetch_stage_if imem ();
  ifu_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .npc_sel(npc_sel), .NPC(NPC),
    .imem(imem.master), .PC_F(PC_F), .Instr_D(Instr_D), .PC_D(PC_D),
    .valid_D(valid_D), .exc_adel_D(exc_adel_D), .fetch_busy(fetch_busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  // drive one cycle, check F-side outputs before the edge and the F/D register after it
  task automatic cyc(input logic rs, st, ns, input logic [31:0] npc, input logic rdy,
                     input logic [31:0] rd, input logic ereq, ebusy,
                     input logic [31:0] e_instr, e_pcd, input logic ev, ee,
                     input logic [31:0] e_pcf);
    exp_t x;
    @(negedge clk);
    reset = rs; stall = st; npc_sel = ns; NPC = npc;
    imem.imem_ready = rdy; imem.imem_rdata = rd;
    #1;
    chk("imem_addr", imem.imem_addr, cur_pc);
    chk("imem_req", {31'd0, imem.imem_req}, {31'd0, ereq});
    chk("fetch_busy", {31'd0, fetch_busy}, {31'd0, ebusy});
    q.push_back('{e_instr, e_pcd, ev, ee, e_pcf});
    @(posedge clk);
    #1;
    x = q.pop_front();
    chk("Instr_D", Instr_D, x.instr);
    chk("PC_D", PC_D, x.pcd);
    chk("valid_D", {31'd0, valid_D}, {31'd0, x.v});
    chk("exc_adel_D", {31'd0, exc_adel_D}, {31'd0, x.e});
    chk("PC_F", PC_F, x.pcf);
    cur_pc = x.pcf;
  endtask
  initial begin
    reset = 1'b1; stall = 1'b0; npc_sel = 1'b0; NPC = '0;
    imem.imem_ready = 1'b0; imem.imem_rdata = '0;
    @(posedge clk); #1;
    chk("rst PC_F", PC_F, 32'h3000);
    chk("rst Instr_D", Instr_D, 32'd0);
    chk("rst PC_D", PC_D, 32'd0);
    chk("rst valid_D", {31'd0, valid_D}, 32'd0);
    chk("rst exc", {31'd0, exc_adel_D}, 32'd0);
    cur_pc = 32'h3000;
    // zero-wait stream
    cyc(0,0,0,0, 1,32'h24010001, 1,0, 32'h24010001,32'h3000,1,0, 32'h3004);
    cyc(0,0,0,0, 1,32'h24020002, 1,0, 32'h24020002,32'h3004,1,0, 32'h3008);
    // two wait cycles give two bubbles
    cyc(0,0,0,0, 0,32'hBAD0BAD0, 1,1, 32'd0,32'h3008,0,0, 32'h3008);
    cyc(0,0,0,0, 0,32'hBAD0BAD0, 1,1, 32'd0,32'h3008,0,0, 32'h3008);
    cyc(0,0,0,0, 1,32'h24030003, 1,0, 32'h24030003,32'h3008,1,0, 32'h300C);
    // word arrives under stall: buffered, F/D and PC held
    cyc(0,1,0,0, 1,32'h24040004, 1,0, 32'h24030003,32'h3008,1,0, 32'h300C);
    cyc(0,1,0,0, 1,32'hDEADBEEF, 0,0, 32'h24030003,32'h3008,1,0, 32'h300C);
    cyc(0,1,1,32'h5000, 0,32'hDEADBEEF, 0,0, 32'h24030003,32'h3008,1,0, 32'h300C);
    cyc(0,0,0,0, 0,32'hDEADBEEF, 0,0, 32'h24040004,32'h300C,1,0, 32'h3010);
    // redirect on a fire cycle
    cyc(0,0,1,32'h3100, 1,32'h24050005, 1,0, 32'h24050005,32'h3010,1,0, 32'h3100);
    // redirect while F waits is latched, applied after the delay slot
    cyc(0,0,1,32'h3200, 0,32'h0, 1,1, 32'd0,32'h3100,0,0, 32'h3100);
    cyc(0,0,0,0, 0,32'h0, 1,1, 32'd0,32'h3100,0,0, 32'h3100);
    cyc(0,0,0,0, 1,32'h24060006, 1,0, 32'h24060006,32'h3100,1,0, 32'h3200);
    cyc(0,0,0,0, 1,32'h24070007, 1,0, 32'h24070007,32'h3200,1,0, 32'h3204);
    // misaligned and out-of-range fetches raise AdEL with a nop
    cyc(0,0,1,32'h3002, 1,32'h24080008, 1,0, 32'h24080008,32'h3204,1,0, 32'h3002);
    cyc(0,0,1,32'h7000, 1,32'hFFFFFFFF, 0,0, 32'd0,32'h3002,1,1, 32'h7000);
    cyc(0,0,1,32'h3010, 0,32'hFFFFFFFF, 0,0, 32'd0,32'h7000,1,1, 32'h3010);
    cyc(0,0,0,0, 0,32'h0, 1,1, 32'd0,32'h3010,0,0, 32'h3010);
    // reset mid-wait wins over a stale ready
    cyc(1,0,0,0, 1,32'hDEADDEAD, 1,0, 32'd0,32'd0,0,0, 32'h3000);
    cyc(0,0,0,0, 0,32'h0, 1,1, 32'd0,32'h3000,0,0, 32'h3000);
    cyc(0,0,0,0, 1,32'h24090009, 1,0, 32'h24090009,32'h3000,1,0, 32'h3004);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/ifu_fetch_stage.md
Name: ifu_fetch_stage

Overview:
- F-stage fetch unit of the pipelined MIPS core.
- Holds the F-stage PC and drives a request/ready instruction-memory port.
- Owns the F/D pipeline register; consumes the next-PC selection and target produced by the D-stage NPC unit.
- Tolerates multi-cycle memory latency and hazard-unit stalls, inserting bubbles into D when no instruction is available.

Parameters:
PC_RESET, 32'h00003000, PC_F value after reset
IM_BASE, 32'h00003000, lowest legal fetch address
IM_LIMIT, 32'h00006FFC, highest legal fetch address (inclusive)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hazard-unit stall; holds PC_F and the F/D register
npc_sel  input  1  D-stage NPC unit requests a redirect (branch/jump in D)
NPC  input  32  redirect target from the D-stage NPC unit
imem_req  output  1  instruction-memory request
imem_addr  output  32  fetch address, equals PC_F
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  memory response, same cycle as request or later
PC_F  output  32  current fetch PC
Instr_D  output  32  F/D register instruction (0 = nop/bubble)
PC_D  output  32  F/D register PC
valid_D  output  1  Instr_D is a real instruction
exc_adel_D  output  1  instruction in D raised a fetch address error
fetch_busy  output  1  F has no instruction this cycle (state FETCH, imem_ready=0, address legal)

Behaviour:
- Reset values (reset=1 at an edge): PC_F=PC_RESET, Instr_D=0, PC_D=0, valid_D=0, exc_adel_D=0, state=FETCH, pending_valid=0, pending_pc=0, buf=0.
- Reset has priority over every other input. Reset asserted while a request is outstanding: the request is abandoned, and any later imem_ready for it is ignored.
- Address check: bad = (PC_F[1:0]!=0) || PC_F<IM_BASE || PC_F>IM_LIMIT.
- imem_req = (state==FETCH) && !bad. imem_addr = PC_F at all times.
- States:
  - FETCH: request outstanding.
  - HOLD: word captured in buf; pipeline stalled; imem_req=0.
- avail = (FETCH && (imem_ready || bad)) || HOLD.
- word = HOLD ? buf : (bad ? 0 : imem_rdata).
- fire = avail && !stall.
- Transitions:
  - FETCH, imem_ready=1, stall=1, !bad: buf<=imem_rdata, go to HOLD.
  - HOLD with !stall: fire, go to FETCH.
  - FETCH with fire: stay in FETCH; a new request is issued for the new PC next cycle.
- On fire:
  - Instr_D<=word, PC_D<=PC_F, valid_D<=1, exc_adel_D<=bad (Instr_D=0 when bad).
  - PC_F<=npc_sel ? NPC : (pending_valid ? pending_pc : PC_F+4). Arithmetic is modulo 2^32.
  - pending_valid<=0.
- On !stall && !fire (bubble): Instr_D<=0, valid_D<=0, exc_adel_D<=0, PC_D<=PC_F, PC_F unchanged.
- On stall: F/D register and PC_F hold. State may still move FETCH->HOLD.
- Redirect latch (delay-slot semantics):
  - npc_sel=1 && !stall && !fire (the branch leaves D before its delay slot arrives): pending_valid<=1, pending_pc<=NPC.
  - npc_sel=1 with pending_valid already 1: newer NPC overwrites pending_pc.
  - npc_sel=1 with stall=1: ignored, because the D instruction is held and re-presents npc_sel.
- Latency: with zero-wait memory (imem_ready combinational same cycle) and no stall, one instruction per cycle. An N-cycle memory wait gives N bubbles.
- imem_rdata is sampled only when imem_ready=1 in FETCH.

Test Plan:
1. Reset, then zero-wait memory returning 32'h24010001, 32'h24020002, no stall -> PC_F steps 0x3000, 0x3004, 0x3008; PC_D=0x3000 then 0x3004; valid_D=1 each cycle.
2. Memory ready 2 cycles after req at 0x3004 -> fetch_busy=1 for 2 cycles, Instr_D=0 and valid_D=0 for 2 cycles, then Instr_D=word and PC_D=0x3004.
3. imem_ready=1 while stall=1 for 3 cycles -> state HOLD, imem_req=0, Instr_D/PC_D/PC_F unchanged; on stall release Instr_D=buffered word, PC_F=PC+4.
4. npc_sel=1, NPC=0x3100 on a fire cycle at PC_F=0x3008 -> PC_D=0x3008 (delay slot) and PC_F=0x3100 next cycle.
5. npc_sel=1, NPC=0x3200 while F waits (no fire), memory ready 2 cycles later -> delay slot enters D, next PC_F=0x3200, pending_valid cleared.
6. Redirect to 0x3002, and separately to 0x7000 -> imem_req=0 at each, Instr_D=0, valid_D=1, exc_adel_D=1, PC_D=0x3002 / 0x7000; assert reset mid-wait -> PC_F=0x3000, state FETCH, stale imem_ready ignored.
